// File: rtl/proj_sorter_ctrl.sv
// Per-document sequencer for the MinHash smallest-K sorter: clears the sorter, streams elements,
// drains the sorter pipeline and holds the K smallest indices until the consumer takes them.
module proj_sorter_ctrl #(
    parameter int unsigned INDICES_COUNT  = 8,
    parameter int unsigned INDICE_LEN     = 8,
    parameter int unsigned SIGNATURE_LEN  = 32,
    parameter int unsigned SORTER_LATENCY = 1
) (
    input  logic                                in_clk,
    input  logic                                in_rst,
    input  logic                                in_valid,
    output logic                                out_ready,
    input  logic [SIGNATURE_LEN-1:0]            in_signature,
    input  logic [INDICE_LEN-1:0]               in_index,
    input  logic                                in_last,
    output logic                                out_srt_rst_n,
    output logic [SIGNATURE_LEN-1:0]            out_srt_signature,
    output logic [INDICE_LEN-1:0]               out_srt_index,
    input  logic [INDICES_COUNT*INDICE_LEN-1:0] in_srt_smallest_idx,
    output logic                                out_res_valid,
    input  logic                                in_res_ready,
    output logic [INDICES_COUNT*INDICE_LEN-1:0] out_res_idx,
    output logic [15:0]                         out_res_count,
    output logic                                out_res_short
);
    localparam int unsigned ResW   = INDICES_COUNT * INDICE_LEN;
    localparam int unsigned DrainW = $clog2(SORTER_LATENCY + 1);

    typedef enum logic [1:0] {StClear, StStream, StDrain, StResult} state_e;

    state_e            state_q, state_d;
    logic [15:0]       count_q, count_d;
    logic [DrainW-1:0] drain_q, drain_d;
    logic [ResW-1:0]   res_idx_q, res_idx_d;
    logic [15:0]       res_count_q, res_count_d;
    logic              res_short_q, res_short_d;
    logic              accept;
    logic              drain_done;

    assign accept     = in_valid && out_ready;
    assign drain_done = (drain_q == DrainW'(1));

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q     <= StClear;
            count_q     <= '0;
            drain_q     <= '0;
            res_idx_q   <= '0;
            res_count_q <= '0;
            res_short_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            drain_q     <= drain_d;
            res_idx_q   <= res_idx_d;
            res_count_q <= res_count_d;
            res_short_q <= res_short_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StClear:  state_d = StStream;
            StStream: if (accept && in_last) state_d = StDrain;
            StDrain:  if (drain_done) state_d = StResult;
            StResult: if (in_res_ready) state_d = StClear;
            default:  state_d = StClear;
        endcase
    end

    always_comb begin
        count_d     = count_q;
        drain_d     = drain_q;
        res_idx_d   = res_idx_q;
        res_count_d = res_count_q;
        res_short_d = res_short_q;
        case (state_q)
            StClear: count_d = '0;
            StStream: begin
                if (accept && count_q != 16'hFFFF) count_d = count_q + 16'd1;
                // Preloaded every streaming cycle so it is ready on the edge into DRAIN
                drain_d = DrainW'(SORTER_LATENCY);
            end
            StDrain: begin
                drain_d = drain_q - DrainW'(1);
                if (drain_done) begin
                    res_idx_d   = in_srt_smallest_idx;
                    res_count_d = count_q;
                    res_short_d = (32'(count_q) < INDICES_COUNT);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        out_ready     = 1'b0;
        out_srt_rst_n = 1'b1;
        out_res_valid = 1'b0;
        case (state_q)
            StClear:  out_srt_rst_n = 1'b0;
            StStream: out_ready     = 1'b1;
            StResult: out_res_valid = 1'b1;
            default: ;
        endcase
    end

    // All-ones signature never displaces a sorter entry, so idle cycles are neutral
    assign out_srt_signature = accept ? in_signature : '1;
    assign out_srt_index     = accept ? in_index : '0;

    assign out_res_idx   = res_idx_q;
    assign out_res_count = res_count_q;
    assign out_res_short = res_short_q;

endmodule

// File: tb/tb_proj_sorter_ctrl.sv
// Bench for proj_sorter_ctrl: behavioural smallest-K sorters around a latency-1 and a
// latency-3 instance, cycle vectors plus directed document sequences.
module tb_proj_sorter_ctrl;
    localparam int K  = 8;
    localparam int EW = 40;
    localparam logic [31:0] SENT = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        a_valid = 1'b0, a_last = 1'b0, a_res_ready = 1'b0;
    logic [31:0] a_sig = '0;
    logic [7:0]  a_idx = '0;
    logic        a_ready, a_srt_rst_n, a_res_valid, a_res_short;
    logic [31:0] a_srt_sig;
    logic [7:0]  a_srt_idx;
    logic [63:0] a_srt_out, a_res_idx;
    logic [15:0] a_res_count;

    logic        b_valid = 1'b0, b_last = 1'b0, b_res_ready = 1'b1;
    logic [31:0] b_sig = '0;
    logic [7:0]  b_idx = '0;
    logic        b_ready, b_srt_rst_n, b_res_valid, b_res_short;
    logic [31:0] b_srt_sig;
    logic [7:0]  b_srt_idx;
    logic [63:0] b_srt_out, b_res_idx;
    logic [15:0] b_res_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    proj_sorter_ctrl #(.SORTER_LATENCY(1)) dut_a (
        .in_clk(clk), .in_rst(rst), .in_valid(a_valid), .out_ready(a_ready),
        .in_signature(a_sig), .in_index(a_idx), .in_last(a_last),
        .out_srt_rst_n(a_srt_rst_n), .out_srt_signature(a_srt_sig), .out_srt_index(a_srt_idx),
        .in_srt_smallest_idx(a_srt_out), .out_res_valid(a_res_valid),
        .in_res_ready(a_res_ready), .out_res_idx(a_res_idx), .out_res_count(a_res_count),
        .out_res_short(a_res_short)
    );

    proj_sorter_ctrl #(.SORTER_LATENCY(3)) dut_b (
        .in_clk(clk), .in_rst(rst), .in_valid(b_valid), .out_ready(b_ready),
        .in_signature(b_sig), .in_index(b_idx), .in_last(b_last),
        .out_srt_rst_n(b_srt_rst_n), .out_srt_signature(b_srt_sig), .out_srt_index(b_srt_idx),
        .in_srt_smallest_idx(b_srt_out), .out_res_valid(b_res_valid),
        .in_res_ready(b_res_ready), .out_res_idx(b_res_idx), .out_res_count(b_res_count),
        .out_res_short(b_res_short)
    );

    // Sorter model: K ascending {sig, idx} slots; a new element goes before the first
    // strictly larger signature, so equal all-ones sentinels never move anything.
    function automatic logic [K*EW-1:0] srt_insert(input logic [K*EW-1:0] st,
                                                   input logic [31:0] s, input logic [7:0] ix);
        logic [K*EW-1:0] r;
        int pos;
        r   = st;
        pos = K;
        for (int j = K - 1; j >= 0; j--) if (s < st[j*EW+8 +: 32]) pos = j;
        if (pos < K) begin
            for (int j = K - 1; j > pos; j--) r[j*EW +: EW] = st[(j-1)*EW +: EW];
            r[pos*EW +: EW] = {s, ix};
        end
        return r;
    endfunction

    function automatic logic [63:0] srt_idx(input logic [K*EW-1:0] st);
        logic [63:0] r;
        for (int j = 0; j < K; j++) r[j*8 +: 8] = st[j*EW +: 8];
        return r;
    endfunction

    localparam logic [K*EW-1:0] SRT_INIT = {K{40'hFFFF_FFFF_00}};

    logic [K*EW-1:0] a_st = SRT_INIT;
    logic [K*EW-1:0] b_st = SRT_INIT;
    logic [63:0]     b_d1 = '0;
    logic [63:0]     b_d2 = '0;

    always @(posedge clk or negedge a_srt_rst_n)
        if (!a_srt_rst_n) a_st <= SRT_INIT;
        else              a_st <= srt_insert(a_st, a_srt_sig, a_srt_idx);
    assign a_srt_out = srt_idx(a_st);

    always @(posedge clk or negedge b_srt_rst_n)
        if (!b_srt_rst_n) b_st <= SRT_INIT;
        else              b_st <= srt_insert(b_st, b_srt_sig, b_srt_idx);
    always @(posedge clk) begin
        b_d1 <= srt_idx(b_st);
        b_d2 <= b_d1;
    end
    assign b_srt_out = b_d2;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic a_send(input logic [31:0] s, input logic [7:0] ix, input logic last);
        a_valid = 1'b1;
        a_sig   = s;
        a_idx   = ix;
        a_last  = last;
        #1;
        chk("send_ready", a_ready, 1);
        chk("send_srt_sig", a_srt_sig, s);
        chk("send_srt_idx", a_srt_idx, ix);
        @(negedge clk);
        a_valid = 1'b0;
        a_last  = 1'b0;
    endtask

    task automatic a_wait_res();
        bit ok = 0;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (a_res_valid) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk("res_timeout", ok, 1);
    endtask

    // Handshake in cycle r, ends at the first STREAM cycle r+2
    task automatic a_finish_res();
        a_res_ready = 1'b1;
        @(negedge clk);
        a_res_ready = 1'b0;
        @(negedge clk);
    endtask

    typedef struct packed {
        logic        v;
        logic [31:0] s;
        logic [7:0]  ix;
        logic        l;
        logic        rr;
        logic        e_ready;
        logic        e_rstn;
        logic [31:0] e_sig;
        logic [7:0]  e_idx;
        logic        e_rv;
        logic        e_res;
    } vec_t;

    vec_t        vt[13];
    logic [31:0] rs[20];
    logic [7:0]  ri[20];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] exp_idx;
        bit          used[20];
        int          best, gap, drain, seen, drain2;
        bit          got;

        vt[0]  = '{1'b1, 32'h5, 8'hA, 1'b0, 1'b0, 1'b1, 1'b1, 32'h5, 8'hA, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 32'h7, 8'h7, 1'b0, 1'b0, 1'b1, 1'b1, SENT, 8'h0, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 32'h3, 8'hB, 1'b0, 1'b0, 1'b1, 1'b1, 32'h3, 8'hB, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 32'h9, 8'hC, 1'b1, 1'b0, 1'b1, 1'b1, 32'h9, 8'hC, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 32'h1, 8'h1, 1'b1, 1'b0, 1'b0, 1'b1, SENT, 8'h0, 1'b0, 1'b0};
        for (int r = 5; r < 10; r++)
            vt[r] = '{1'b1, 32'h1, 8'h1, 1'b1, 1'b0, 1'b0, 1'b1, SENT, 8'h0, 1'b1, 1'b1};
        vt[10] = '{1'b0, 32'h0, 8'h0, 1'b0, 1'b1, 1'b0, 1'b1, SENT, 8'h0, 1'b1, 1'b1};
        vt[11] = '{1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0, SENT, 8'h0, 1'b0, 1'b1};
        vt[12] = '{1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b1, 1'b1, SENT, 8'h0, 1'b0, 1'b1};

        // Reset values
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_ready", a_ready, 0);
        chk("rst_srt_rst_n", a_srt_rst_n, 0);
        chk("rst_srt_sig", a_srt_sig, SENT);
        chk("rst_srt_idx", a_srt_idx, 0);
        chk("rst_res_valid", a_res_valid, 0);
        chk("rst_res_idx", a_res_idx, 0);
        chk("rst_res_count", a_res_count, 0);
        chk("rst_res_short", a_res_short, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("clear_ready", a_ready, 0);
        chk("clear_srt_rst_n", a_srt_rst_n, 0);
        @(negedge clk);

        // Ten elements, exact result latency
        a_res_ready = 1'b1;
        for (int i = 10; i >= 1; i--) a_send(32'(i) * 32'h1010_1010, 8'(i), i == 1);
        #1;
        chk("t1_drain_valid", a_res_valid, 0);
        chk("t1_drain_ready", a_ready, 0);
        chk("t1_drain_sig", a_srt_sig, SENT);
        @(negedge clk);
        #1;
        chk("t1_res_valid", a_res_valid, 1);
        chk("t1_res_idx", a_res_idx, 64'h0807_0605_0403_0201);
        chk("t1_res_count", a_res_count, 10);
        chk("t1_res_short", a_res_short, 0);
        @(negedge clk);
        #1;
        chk("t1_after_valid", a_res_valid, 0);
        chk("t1_after_rst_n", a_srt_rst_n, 0);
        @(negedge clk);
        #1;
        chk("t1_after_ready", a_ready, 1);
        a_res_ready = 1'b0;
        @(negedge clk);

        // Short document, gap, held result, handshake
        for (int r = 0; r < 13; r++) begin
            a_valid     = vt[r].v;
            a_sig       = vt[r].s;
            a_idx       = vt[r].ix;
            a_last      = vt[r].l;
            a_res_ready = vt[r].rr;
            #1;
            chk($sformatf("vec%0d_ready", r), a_ready, vt[r].e_ready);
            chk($sformatf("vec%0d_srt_rst_n", r), a_srt_rst_n, vt[r].e_rstn);
            chk($sformatf("vec%0d_srt_sig", r), a_srt_sig, vt[r].e_sig);
            chk($sformatf("vec%0d_srt_idx", r), a_srt_idx, vt[r].e_idx);
            chk($sformatf("vec%0d_res_valid", r), a_res_valid, vt[r].e_rv);
            if (vt[r].e_res) begin
                chk($sformatf("vec%0d_res_idx", r), a_res_idx, 64'h0000_0000_000C_0A0B);
                chk($sformatf("vec%0d_res_count", r), a_res_count, 3);
                chk($sformatf("vec%0d_res_short", r), a_res_short, 1);
            end
            @(negedge clk);
        end
        a_valid     = 1'b0;
        a_last      = 1'b0;
        a_res_ready = 1'b0;

        // Twenty random elements with idle cycles in between
        for (int i = 0; i < 20; i++) begin
            rs[i] = {16'($urandom_range(0, 65535)), 16'(i)};
            ri[i] = 8'($urandom_range(0, 255));
            a_send(rs[i], ri[i], i == 19);
            if (i != 19) begin
                #1;
                chk("rnd_gap_sig", a_srt_sig, SENT);
                chk("rnd_gap_idx", a_srt_idx, 0);
                @(negedge clk);
            end
        end
        for (int j = 0; j < 20; j++) used[j] = 0;
        exp_idx = '0;
        for (int k = 0; k < K; k++) begin
            best = -1;
            for (int j = 0; j < 20; j++)
                if (!used[j] && (best < 0 || rs[j] < rs[best])) best = j;
            used[best] = 1;
            exp_idx[k*8 +: 8] = ri[best];
        end
        a_wait_res();
        chk("rnd_res_idx", a_res_idx, exp_idx);
        chk("rnd_res_count", a_res_count, 20);
        chk("rnd_res_short", a_res_short, 0);
        a_finish_res();

        // Reset in the middle of the second element
        a_send(32'h2, 8'h55, 1'b0);
        a_valid = 1'b1;
        a_sig   = 32'h1;
        a_idx   = 8'h66;
        #2;
        rst = 1'b1;
        #1;
        chk("abort_ready", a_ready, 0);
        chk("abort_srt_rst_n", a_srt_rst_n, 0);
        chk("abort_srt_sig", a_srt_sig, SENT);
        chk("abort_srt_idx", a_srt_idx, 0);
        chk("abort_res_valid", a_res_valid, 0);
        chk("abort_res_idx", a_res_idx, 0);
        chk("abort_res_count", a_res_count, 0);
        chk("abort_res_short", a_res_short, 0);
        @(negedge clk);
        rst     = 1'b0;
        a_valid = 1'b0;
        #1;
        chk("abort_clear", a_srt_rst_n, 0);
        @(negedge clk);
        a_send(32'd40, 8'h1, 1'b0);
        a_send(32'd10, 8'h2, 1'b0);
        a_send(32'd30, 8'h3, 1'b0);
        a_send(32'd20, 8'h4, 1'b1);
        a_wait_res();
        chk("abort_new_idx", a_res_idx, 64'h0000_0000_0103_0402);
        chk("abort_new_count", a_res_count, 4);
        chk("abort_new_short", a_res_short, 1);
        a_finish_res();

        // Latency-3 instance, back-to-back documents
        b_valid = 1'b1;
        b_sig   = 32'd100;
        b_idx   = 8'h1;
        b_last  = 1'b0;
        #1;
        chk("b_first_ready", b_ready, 1);
        @(negedge clk);
        b_sig  = 32'd50;
        b_idx  = 8'h2;
        b_last = 1'b1;
        #1;
        chk("b_last_ready", b_ready, 1);
        @(negedge clk);
        b_sig  = 32'd7;
        b_idx  = 8'h9;
        b_last = 1'b0;
        gap    = 0;
        drain  = 0;
        seen   = 0;
        got    = 0;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (b_ready) begin
                got = 1;
                break;
            end
            gap++;
            if (b_res_valid) begin
                seen++;
                chk("b_doc1_idx", b_res_idx, 64'h0000_0000_0000_0102);
                chk("b_doc1_count", b_res_count, 2);
                chk("b_doc1_short", b_res_short, 1);
            end else if (b_srt_rst_n) begin
                drain++;
            end
            @(negedge clk);
        end
        chk("b_doc2_start", got, 1);
        chk("b_gap_cycles", gap, 5);
        chk("b_drain_cycles", drain, 3);
        chk("b_result_cycles", seen, 1);
        @(negedge clk);
        b_sig  = 32'd3;
        b_idx  = 8'h8;
        b_last = 1'b1;
        #1;
        chk("b_doc2_last_ready", b_ready, 1);
        @(negedge clk);
        b_valid = 1'b0;
        b_last  = 1'b0;
        drain2  = 0;
        got     = 0;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (b_res_valid) begin
                got = 1;
                break;
            end
            drain2++;
            @(negedge clk);
        end
        chk("b_doc2_res_seen", got, 1);
        chk("b_doc2_drain_cycles", drain2, 3);
        chk("b_doc2_idx", b_res_idx, 64'h0000_0000_0000_0908);
        chk("b_doc2_count", b_res_count, 2);
        chk("b_doc2_short", b_res_short, 1);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/proj_sorter_ctrl.md
# proj_sorter_ctrl

Per-document sequencer for the MinHash smallest-K sorter. It accepts the hasher's (signature, index) stream with a valid/ready handshake and clears the sorter at each document boundary. Between documents it feeds the sorter neutral sentinels, drains the sorter pipeline after the last element, then captures the K smallest indices and holds them until the downstream consumer accepts them.

## Interface
- INDICES_COUNT, 8, K: number of smallest indices the sorter keeps.
- INDICE_LEN, 8, width of one index.
- SIGNATURE_LEN, 32, width of one signature.
- SORTER_LATENCY, 1, cycles from the sorter sampling an element to `out_smallest_idx` reflecting it (≥1).
- in_clk  input  1  clock; all logic is rising-edge.
- in_rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  upstream element valid.
- out_ready  output  1  controller accepts the element this cycle.
- in_signature  input  SIGNATURE_LEN  element signature.
- in_index  input  INDICE_LEN  element index.
- in_last  input  1  the element is the last one of its document; qualified by in_valid.
- out_srt_rst_n  output  1  active-low clear to the sorter's `in_rst_n`.
- out_srt_signature  output  SIGNATURE_LEN  signature to the sorter.
- out_srt_index  output  INDICE_LEN  index to the sorter.
- in_srt_smallest_idx  input  INDICES_COUNT*INDICE_LEN  sorter `out_smallest_idx`, slot 0 in the LSBs.
- out_res_valid  output  1  result valid.
- in_res_ready  input  1  consumer accepts the result.
- out_res_idx  output  INDICES_COUNT*INDICE_LEN  captured smallest indices.
- out_res_count  output  16  number of elements in the document, saturating at 0xFFFF.
- out_res_short  output  1  out_res_count < INDICES_COUNT, so the upper slots hold no real elements.

## Operation
- The FSM has four states: CLEAR, STREAM, DRAIN and RESULT. The reset state is CLEAR.
- CLEAR
  - out_srt_rst_n=0 and out_ready=0.
  - The element counter is zeroed.
  - Always moves to STREAM after 1 cycle.
- STREAM
  - out_ready=1; an element is accepted when in_valid && out_ready.
  - On an accepted cycle, out_srt_signature/index are driven combinationally from the inputs and the counter increments, saturating at 0xFFFF.
  - On a non-accepted cycle, the sentinel is driven: signature all-ones, index 0. The sorter never displaces an entry with an equal all-ones value, so sentinels are neutral.
  - An accepted element with in_last=1 moves the FSM to DRAIN.
- DRAIN
  - out_ready=0 and the sentinel is driven.
  - A down-counter loaded with SORTER_LATENCY keeps the FSM here for exactly SORTER_LATENCY cycles.
  - On the edge that ends the final DRAIN cycle, in_srt_smallest_idx is captured into out_res_idx, and out_res_count and out_res_short are registered. The FSM then moves to RESULT.
- RESULT
  - out_res_valid=1, out_ready=0, sentinel driven.
  - The outputs are held stable until in_res_ready=1, then the FSM moves to CLEAR.
- out_res_idx, out_res_count and out_res_short keep their last value outside RESULT. Only out_res_valid qualifies them.
- A document always contains at least 1 element, because in_last is only meaningful with in_valid.

## Timing
- Reset values: out_ready=0, out_srt_rst_n=0, out_srt_signature=all-ones, out_srt_index=0, out_res_valid=0, out_res_idx=0, out_res_count=0, out_res_short=0. The FSM is in CLEAR.
- After in_rst deasserts, the first edge leaves CLEAR, so out_ready=1 from the 2nd cycle.
- Latency for a document whose first element is accepted in cycle t and which has N back-to-back elements:
  - Last element accepted in cycle t+N-1.
  - DRAIN covers cycles t+N .. t+N+SORTER_LATENCY-1.
  - out_res_valid=1 from cycle t+N+SORTER_LATENCY.
- Gaps (in_valid=0) during STREAM insert sentinels and only stretch the timeline.
- If the result handshake completes in cycle r, then out_res_valid=0 in r+1, CLEAR is in r+1, and out_ready=1 in r+2.
- Back-to-back documents therefore have a minimum overhead of SORTER_LATENCY+2 cycles when in_res_ready is tied high.
- in_res_ready outside RESULT is ignored. in_valid, in_signature, in_index and in_last are ignored whenever out_ready=0.
- Asserting in_rst in any state (mid-STREAM, DRAIN or RESULT) asynchronously forces all reset values. The partial document is discarded and no result is emitted. The sorter is cleared, because out_srt_rst_n=0 while in reset.

## Test plan
- Reset, then stream indices 10..1 with signatures i*0x10101010, last on index 1, K=8, latency 1, in_res_ready=1 → out_res_valid exactly 2 cycles after the last accept; out_res_idx slots 0..7 = 1..8; count=10; short=0.
- Stream 3 elements (sig 5,3,9; idx 0xA,0xB,0xC), last on the 3rd → result slots 0..2 = 0xB,0xA,0xC; count=3; short=1.
- Hold in_res_ready=0 for 5 cycles in RESULT → out_res_valid and all result outputs stable, out_ready=0. Assert in_res_ready → out_srt_rst_n=0 the next cycle, out_ready=1 the cycle after.
- In STREAM, alternate in_valid 1/0 with 20 random elements → sentinels on the idle cycles; result equals a reference model of the K smallest over only the accepted elements; count=20.
- Assert in_rst in the middle of the 2nd element of a document → all outputs return to reset values immediately. A new 4-element document then produces a result that contains no data from the aborted one.
- Run SORTER_LATENCY=3 with two back-to-back documents → DRAIN lasts exactly 3 cycles and the documents are separated by exactly 5 cycles of out_ready=0.
